demux_259_sync: RTL and testbench

- Clocked dual 1-to-4 addressable latch and demultiplexer: the write-side counterpart of the dual 4-to-1 253-style selector.
- Takes the single-bit streams the 253 emits on y1/y2 under a shared sel and rebuilds two 4-bit nibbles.
- Keeps a per-unit fill mask and emits a one-cycle strobe with a frozen capture when all positions have been written.
- Sits on the receiving side of bit-serial paths in the datapath and microcode test harnesses.

---
 rtl/demux_259_sync_pkg.sv | 18 +
 rtl/demux_259_sync_unit.sv | 84 ++++++++
 rtl/demux_259_sync.sv | 53 +++++
 tb/tb_demux_259_sync.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/demux_259_sync_pkg.sv
// Shared definitions for the synchronous dual 1-to-4 addressable latch:
// default select width and the {nclr, nen} mode encodings.
package demux_259_sync_pkg;

  localparam int SELW_DEFAULT = 2;

  typedef enum logic [1:0] {
    MODE_DEMUX = 2'b00,
    MODE_CLEAR = 2'b01,
    MODE_LATCH = 2'b10,
    MODE_HOLD  = 2'b11
  } mode_e;

  function automatic mode_e decode_mode(input logic nclr, input logic nen);
    return mode_e'({nclr, nen});
  endfunction

endpackage

// File: rtl/demux_259_sync_unit.sv
// One 259-style addressable latch unit: live contents, fill mask, and an
// optional capture register with a one-cycle completion strobe.
module demux_259_sync_unit
  import demux_259_sync_pkg::*;
#(
  parameter int SELW       = SELW_DEFAULT,
  parameter bit CAPTURE_EN = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [SELW-1:0]      sel,
  input  logic                 d,
  input  logic                 nen,
  input  logic                 nclr,
  output logic [(2**SELW)-1:0] q,
  output logic [(2**SELW)-1:0] mask,
  output logic [(2**SELW)-1:0] cap,
  output logic                 done
);

  localparam int N = 2**SELW;

  logic [N-1:0] q_d,    q_q;
  logic [N-1:0] mask_d, mask_q;
  logic [N-1:0] cap_d,  cap_q;
  logic         done_d, done_q;
  mode_e        mode;

  assign mode = decode_mode(nclr, nen);

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned,
    // which is what keeps this block free of inferred latches.
    q_d    = q_q;
    mask_d = mask_q;
    cap_d  = cap_q;
    done_d = 1'b0;
    unique case (mode)
      MODE_HOLD: ;
      MODE_LATCH: begin
        q_d[sel]    = d;
        mask_d[sel] = 1'b1;
        // Completion only from latch mode; q keeps its contents, mask restarts.
        if (&mask_d) begin
          cap_d  = CAPTURE_EN ? q_d : '0;
          done_d = CAPTURE_EN;
          mask_d = '0;
        end
      end
      MODE_CLEAR: begin
        q_d    = '0;
        mask_d = '0;
      end
      MODE_DEMUX: begin
        q_d         = '0;
        q_d[sel]    = d;
        mask_d      = '0;
        mask_d[sel] = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_q    <= '0;
      mask_q <= '0;
      cap_q  <= '0;
      done_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values,
      // independent of statement order.
      q_q    <= q_d;
      mask_q <= mask_d;
      cap_q  <= cap_d;
      done_q <= done_d;
    end
  end

  assign q    = q_q;
  assign mask = mask_q;
  assign cap  = cap_q;
  assign done = done_q;

endmodule

// File: rtl/demux_259_sync.sv
// Clocked dual 1-to-4 addressable latch / demultiplexer: two independent
// 259-style units sharing sel and nclr, rebuilding nibbles from bit streams.
module demux_259_sync
  import demux_259_sync_pkg::*;
#(
  parameter int SELW       = SELW_DEFAULT,
  parameter bit CAPTURE_EN = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [SELW-1:0]      sel,
  input  logic                 d1,
  input  logic                 d2,
  input  logic                 nen1,
  input  logic                 nen2,
  input  logic                 nclr,
  output logic [(2**SELW)-1:0] q1,
  output logic [(2**SELW)-1:0] q2,
  output logic [(2**SELW)-1:0] mask1,
  output logic [(2**SELW)-1:0] mask2,
  output logic [(2**SELW)-1:0] cap1,
  output logic [(2**SELW)-1:0] cap2,
  output logic                 done1,
  output logic                 done2
);

  demux_259_sync_unit #(.SELW(SELW), .CAPTURE_EN(CAPTURE_EN)) u_unit1 (
    .clk   (clk),
    .reset (reset),
    .sel   (sel),
    .d     (d1),
    .nen   (nen1),
    .nclr  (nclr),
    .q     (q1),
    .mask  (mask1),
    .cap   (cap1),
    .done  (done1)
  );

  demux_259_sync_unit #(.SELW(SELW), .CAPTURE_EN(CAPTURE_EN)) u_unit2 (
    .clk   (clk),
    .reset (reset),
    .sel   (sel),
    .d     (d2),
    .nen   (nen2),
    .nclr  (nclr),
    .q     (q2),
    .mask  (mask2),
    .cap   (cap2),
    .done  (done2)
  );

endmodule

// File: tb/tb_demux_259_sync.sv
// Self-checking bench for demux_259_sync: directed scenarios plus random
// traffic checked against a position/count based reference model.
module tb_demux_259_sync;

  logic       clk;
  logic       reset;
  logic [1:0] sel;
  logic       d1, d2, nen1, nen2, nclr;
  logic [3:0] q1, q2, mask1, mask2, cap1, cap2;
  logic       done1, done2;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: per unit, stored bit and "written" flag per position.
  int         qm[2][4];
  int         wm[2][4];
  logic [3:0] capm[2];
  logic       donem[2];

  demux_259_sync dut (
    .clk   (clk),
    .reset (reset),
    .sel   (sel),
    .d1    (d1),
    .d2    (d2),
    .nen1  (nen1),
    .nen2  (nen2),
    .nclr  (nclr),
    .q1    (q1),
    .q2    (q2),
    .mask1 (mask1),
    .mask2 (mask2),
    .cap1  (cap1),
    .cap2  (cap2),
    .done1 (done1),
    .done2 (done2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0] exp_q(input int u);
    logic [3:0] v;
    for (int i = 0; i < 4; i++) v[i] = (qm[u][i] != 0);
    return v;
  endfunction

  function automatic logic [3:0] exp_mask(input int u);
    logic [3:0] v;
    for (int i = 0; i < 4; i++) v[i] = (wm[u][i] != 0);
    return v;
  endfunction

  task automatic model_reset();
    for (int u = 0; u < 2; u++) begin
      for (int i = 0; i < 4; i++) begin
        qm[u][i] = 0;
        wm[u][i] = 0;
      end
      capm[u]  = 4'b0000;
      donem[u] = 1'b0;
    end
  endtask

  task automatic model_unit(input int u, input int s, input logic c, input logic e, input logic b);
    int count;
    donem[u] = 1'b0;
    if (c && !e) begin
      qm[u][s] = int'(b);
      wm[u][s] = 1;
      count = 0;
      for (int i = 0; i < 4; i++) count += wm[u][i];
      if (count == 4) begin
        capm[u]  = exp_q(u);
        donem[u] = 1'b1;
        for (int i = 0; i < 4; i++) wm[u][i] = 0;
      end
    end else if (!c) begin
      for (int i = 0; i < 4; i++) begin
        qm[u][i] = 0;
        wm[u][i] = 0;
      end
      if (!e) begin
        qm[u][s] = int'(b);
        wm[u][s] = 1;
      end
    end
  endtask

  // Drive one cycle of inputs, let the edge happen, advance the model, and
  // leave time 1 ns after the edge for sampling.
  task automatic step(input int s, input logic c, input logic e1, input logic b1,
                      input logic e2, input logic b2);
    sel  = s[1:0];
    nclr = c;
    nen1 = e1;
    d1   = b1;
    nen2 = e2;
    d2   = b2;
    @(posedge clk);
    model_unit(0, s, c, e1, b1);
    model_unit(1, s, c, e2, b2);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    sel = 2'd0; nclr = 1'b1; nen1 = 1'b1; nen2 = 1'b1; d1 = 1'b0; d2 = 1'b0;
    model_reset();
    #20;
    reset = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step(k % 4, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
      n_tests++;
      if ({q1, q2, mask1, mask2, cap1, cap2, done1, done2} !== 26'd0) begin
        n_fail++;
        $display("FAIL reset_hold cycle %0d: got q=%b/%b mask=%b/%b cap=%b/%b done=%b/%b expected all zero",
                 k, q1, q2, mask1, mask2, cap1, cap2, done1, done2);
      end
    end
  endtask

  task automatic test_fill_unit1();
    logic [3:0] bits = 4'b1101;
    for (int i = 0; i < 4; i++) begin
      step(i, 1'b1, 1'b0, bits[i], 1'b1, 1'b0);
      n_tests++;
      if (done1 !== (i == 3)) begin
        n_fail++;
        $display("FAIL fill1_done write %0d: got %b expected %b", i, done1, (i == 3));
      end
    end
    n_tests++;
    if (q1 !== 4'b1101 || cap1 !== 4'b1101 || mask1 !== 4'b0000) begin
      n_fail++;
      $display("FAIL fill1_result: got q1=%b cap1=%b mask1=%b expected 1101/1101/0000", q1, cap1, mask1);
    end
    n_tests++;
    if (q2 !== 4'b0000 || mask2 !== 4'b0000 || done2 !== 1'b0) begin
      n_fail++;
      $display("FAIL fill1_unit2_idle: got q2=%b mask2=%b done2=%b expected 0000/0000/0", q2, mask2, done2);
    end
    step(0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    n_tests++;
    if (done1 !== 1'b0 || q1 !== 4'b1101) begin
      n_fail++;
      $display("FAIL fill1_after: got done1=%b q1=%b expected 0/1101", done1, q1);
    end
  endtask

  task automatic test_overwrite_unit2();
    int   ss[5] = '{3, 3, 0, 2, 1};
    logic bb[5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 5; i++) begin
      step(ss[i], 1'b1, 1'b1, 1'b0, 1'b0, bb[i]);
      n_tests++;
      if (done2 !== (i == 4)) begin
        n_fail++;
        $display("FAIL overwrite2_done write %0d: got %b expected %b", i, done2, (i == 4));
      end
    end
    n_tests++;
    if (cap2 !== 4'b0101 || q2 !== 4'b0101 || mask2 !== 4'b0000) begin
      n_fail++;
      $display("FAIL overwrite2_result: got cap2=%b q2=%b mask2=%b expected 0101/0101/0000", cap2, q2, mask2);
    end
  endtask

  task automatic test_demux();
    for (int i = 0; i < 4; i++) step(i, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    n_tests++;
    if (q1 !== 4'b1111) begin
      n_fail++;
      $display("FAIL demux_prefill: got q1=%b expected 1111", q1);
    end
    step(2, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    n_tests++;
    if (q1 !== 4'b0100 || mask1 !== 4'b0100 || done1 !== 1'b0) begin
      n_fail++;
      $display("FAIL demux_write: got q1=%b mask1=%b done1=%b expected 0100/0100/0", q1, mask1, done1);
    end
    step(2, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    n_tests++;
    if (q1 !== 4'b0000 || mask1 !== 4'b0000 || q2 !== 4'b0000 || mask2 !== 4'b0000) begin
      n_fail++;
      $display("FAIL demux_clear: got q1=%b mask1=%b q2=%b mask2=%b expected all 0000", q1, mask1, q2, mask2);
    end
  endtask

  task automatic test_midfill_reset();
    for (int i = 0; i < 3; i++) step(i, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    n_tests++;
    if (mask1 !== 4'b0111) begin
      n_fail++;
      $display("FAIL midfill_mask: got mask1=%b expected 0111", mask1);
    end
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    n_tests++;
    if (q1 !== 4'b0000 || mask1 !== 4'b0000 || cap1 !== 4'b0000) begin
      n_fail++;
      $display("FAIL midfill_async_reset: got q1=%b mask1=%b cap1=%b expected 0000/0000/0000", q1, mask1, cap1);
    end
    #1;
    reset = 1'b0;
    step(3, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    n_tests++;
    if (done1 !== 1'b0 || mask1 !== 4'b1000) begin
      n_fail++;
      $display("FAIL midfill_no_done: got done1=%b mask1=%b expected 0/1000", done1, mask1);
    end
  endtask

  // Behavioural 253 source: each unit emits i[sel] for the swept select.
  task automatic test_loopback();
    logic [3:0] i1 = 4'hA;
    logic [3:0] i2 = 4'h5;
    step(0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    for (int s = 0; s < 4; s++) step(s, 1'b1, 1'b0, i1[s], 1'b0, i2[s]);
    n_tests++;
    if (done1 !== 1'b1 || done2 !== 1'b1 || cap1 !== 4'hA || cap2 !== 4'h5) begin
      n_fail++;
      $display("FAIL loopback: got done=%b/%b cap1=%h cap2=%h expected 1/1 A 5", done1, done2, cap1, cap2);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      step($urandom_range(0, 3), ($urandom_range(0, 7) != 0), $urandom_range(0, 1),
           $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1));
      n_tests++;
      if (q1 !== exp_q(0) || mask1 !== exp_mask(0) || cap1 !== capm[0] || done1 !== donem[0] ||
          q2 !== exp_q(1) || mask2 !== exp_mask(1) || cap2 !== capm[1] || done2 !== donem[1]) begin
        n_fail++;
        $display("FAIL random cycle %0d: got q=%b/%b mask=%b/%b cap=%b/%b done=%b/%b expected q=%b/%b mask=%b/%b cap=%b/%b done=%b/%b",
                 k, q1, q2, mask1, mask2, cap1, cap2, done1, done2,
                 exp_q(0), exp_q(1), exp_mask(0), exp_mask(1), capm[0], capm[1], donem[0], donem[1]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_fill_unit1();
    test_overwrite_unit2();
    test_demux();
    test_midfill_reset();
    test_loopback();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
